vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 21 ++
 rtl/sat_counter.sv | 28 ++
 rtl/vram_arbiter.sv | 113 +++++++++++
 tb/tb_vram_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared state encoding, request layout and widths for the VRAM arbiter.
package vram_arbiter_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [3:0]        mask;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear (used by VRAM_ARBITER_STATS_EN).
module sat_counter
    import vram_arbiter_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         reset_n_i,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && !(&r_count))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: two-requester framebuffer arbiter, one downstream access at a time.
// Optional grant counters are built when VRAM_ARBITER_STATS_EN is defined.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int ADDR_W         = vram_arbiter_pkg::ADDR_W,
    parameter int DATA_W         = vram_arbiter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n_i,
`ifdef VRAM_ARBITER_STATS_EN
    input  logic              stat_clear_i,
    output logic [15:0]       stat0_grants_o,
    output logic [15:0]       stat1_grants_o,
`endif
    input  logic              m0_sel_i,
    input  logic              m0_wr_i,
    input  logic [3:0]        m0_mask_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_sel_i,
    input  logic              m1_wr_i,
    input  logic [3:0]        m1_mask_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [3:0]        vram_mask_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic              vram_ack_i,
    input  logic [DATA_W-1:0] vram_data_i
);

    state_t r_state;
    state_t w_next;
    logic   r_last;
    logic   r_owner;
    logic   w_grant;
    logic   w_win;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        w_win   = (m0_sel_i && m1_sel_i) ? (FIXED_PRIORITY ? 1'b0 : ~r_last) : ~m0_sel_i;
        w_grant = (r_state == IDLE) && (m0_sel_i || m1_sel_i);
        w_next  = (r_state == IDLE) ? (w_grant ? BUSY : IDLE) :
                  (r_state == BUSY) ? (vram_ack_i ? RESP : BUSY) : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            vram_sel_o  <= 1'b0;
            vram_wr_o   <= 1'b0;
            vram_mask_o <= '0;
            vram_addr_o <= '0;
            vram_data_o <= '0;
            m0_ack_o    <= 1'b0;
            m1_ack_o    <= 1'b0;
            m0_data_o   <= '0;
            m1_data_o   <= '0;
        end else begin
            vram_sel_o <= (w_next == BUSY);
            m0_ack_o   <= (w_next == RESP) && !r_owner;
            m1_ack_o   <= (w_next == RESP) && r_owner;
            if (w_grant) begin
                r_owner     <= w_win;
                r_last      <= w_win;
                vram_wr_o   <= w_win ? m1_wr_i   : m0_wr_i;
                vram_mask_o <= w_win ? m1_mask_i : m0_mask_i;
                vram_addr_o <= w_win ? m1_addr_i : m0_addr_i;
                vram_data_o <= w_win ? m1_data_i : m0_data_i;
            end
            if (r_state == BUSY && vram_ack_i && !r_owner)
                m0_data_o <= vram_data_i;
            if (r_state == BUSY && vram_ack_i && r_owner)
                m1_data_o <= vram_data_i;
        end
    end

`ifdef VRAM_ARBITER_STATS_EN
    sat_counter #(.W(16)) u_stat0 (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .i_clear   (stat_clear_i),
        .i_inc     (w_grant && !w_win),
        .o_count   (stat0_grants_o)
    );

    sat_counter #(.W(16)) u_stat1 (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .i_clear   (stat_clear_i),
        .i_inc     (w_grant && w_win),
        .o_count   (stat1_grants_o)
    );
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized transaction-level check of vram_arbiter against a behavioural model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sel;
    logic [1:0]  wr;
    logic [3:0]  mask  [2];
    logic [23:0] addr  [2];
    logic [15:0] wdata [2];
    logic        vack;
    logic [15:0] vrd;
    logic        ack0, ack1, vsel, vwr;
    logic [15:0] rd0, rd1, vdat;
    logic [3:0]  vmask;
    logic [23:0] vaddr;
    logic        fack0, fack1, fvsel, fvwr;
    logic [15:0] frd0, frd1, fvdat;
    logic [3:0]  fvmask;
    logic [23:0] fvaddr;
`ifdef VRAM_ARBITER_STATS_EN
    logic        st_clr;
    logic [15:0] st0, st1, fst0, fst1;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          act [2];
    int          last_g;
    logic [15:0] exp_rd [2];

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset_n_i(reset_n),
`ifdef VRAM_ARBITER_STATS_EN
        .stat_clear_i(st_clr), .stat0_grants_o(st0), .stat1_grants_o(st1),
`endif
        .m0_sel_i(sel[0]), .m0_wr_i(wr[0]), .m0_mask_i(mask[0]), .m0_addr_i(addr[0]),
        .m0_data_i(wdata[0]), .m0_ack_o(ack0), .m0_data_o(rd0),
        .m1_sel_i(sel[1]), .m1_wr_i(wr[1]), .m1_mask_i(mask[1]), .m1_addr_i(addr[1]),
        .m1_data_i(wdata[1]), .m1_ack_o(ack1), .m1_data_o(rd1),
        .vram_sel_o(vsel), .vram_wr_o(vwr), .vram_mask_o(vmask), .vram_addr_o(vaddr),
        .vram_data_o(vdat), .vram_ack_i(vack), .vram_data_i(vrd)
    );

    vram_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .reset_n_i(reset_n),
`ifdef VRAM_ARBITER_STATS_EN
        .stat_clear_i(st_clr), .stat0_grants_o(fst0), .stat1_grants_o(fst1),
`endif
        .m0_sel_i(sel[0]), .m0_wr_i(wr[0]), .m0_mask_i(mask[0]), .m0_addr_i(addr[0]),
        .m0_data_i(wdata[0]), .m0_ack_o(fack0), .m0_data_o(frd0),
        .m1_sel_i(sel[1]), .m1_wr_i(wr[1]), .m1_mask_i(mask[1]), .m1_addr_i(addr[1]),
        .m1_data_i(wdata[1]), .m1_ack_o(fack1), .m1_data_o(frd1),
        .vram_sel_o(fvsel), .vram_wr_o(fvwr), .vram_mask_o(fvmask), .vram_addr_o(fvaddr),
        .vram_data_o(fvdat), .vram_ack_i(vack), .vram_data_i(vrd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int n, input logic w, input logic [3:0] m,
                           input logic [23:0] a, input logic [15:0] d);
        act[n]   = 1'b1;
        sel[n]   = 1'b1;
        wr[n]    = w;
        mask[n]  = m;
        addr[n]  = a;
        wdata[n] = d;
    endtask

    task automatic rand_req(input int n);
        new_req(n, 1'($urandom), 4'($urandom), 24'($urandom), 16'($urandom));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vsel"}, vsel, 0);
        check({tag, "_vwr"}, vwr, 0);
        check({tag, "_vmask"}, vmask, 0);
        check({tag, "_vaddr"}, vaddr, 0);
        check({tag, "_vdata"}, vdat, 0);
        check({tag, "_acks"}, {ack1, ack0}, 0);
        check({tag, "_rd0"}, rd0, 0);
        check({tag, "_rd1"}, rd1, 0);
    endtask

    // One complete access: model picks the winner, downstream acks after dly extra BUSY cycles.
    task automatic run_xact(input int dly, input bit drop, input logic [15:0] rdv);
        int w;
        int o;
        w = (act[0] && act[1]) ? (last_g == 0 ? 1 : 0) : (act[0] ? 0 : 1);
        o = 1 - w;
        last_g = w;
        tick();
        check("grant_sel", vsel, 1);
        check("grant_wr", vwr, wr[w]);
        check("grant_mask", vmask, mask[w]);
        check("grant_addr", vaddr, addr[w]);
        check("grant_data", vdat, wdata[w]);
        check("grant_acks", {ack1, ack0}, 0);
        if (drop) sel[w] = 1'b0;
        for (int i = 0; i < dly; i++) begin
            tick();
            check("busy_sel", vsel, 1);
            check("busy_addr", vaddr, addr[w]);
            check("busy_acks", {ack1, ack0}, 0);
        end
        vack = 1'b1;
        vrd  = rdv;
        tick();
        vack = 1'b0;
        vrd  = 16'($urandom);
        exp_rd[w] = rdv;
        check("resp_ack", {ack1, ack0}, (w == 1) ? 2'b10 : 2'b01);
        check("resp_data", (w == 1) ? rd1 : rd0, rdv);
        check("resp_other_data", (o == 1) ? rd1 : rd0, exp_rd[o]);
        check("resp_sel", vsel, 0);
        vack = 1'($urandom_range(0, 1));
        tick();
        vack = 1'b0;
        sel[w] = 1'b0;
        act[w] = 1'b0;
        check("idle_acks", {ack1, ack0}, 0);
        check("idle_sel", vsel, 0);
        check("hold_data", (w == 1) ? rd1 : rd0, rdv);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        sel = '0;
        wr = '0;
        vack = 1'b0;
        vrd = '0;
        for (int n = 0; n < 2; n++) begin
            mask[n] = '0; addr[n] = '0; wdata[n] = '0; act[n] = 1'b0; exp_rd[n] = '0;
        end
`ifdef VRAM_ARBITER_STATS_EN
        st_clr = 1'b0;
`endif
        last_g = 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Continuous tie with immediate acks: round-robin alternates, fixed priority keeps 0.
        rand_req(0);
        rand_req(1);
        for (int i = 0; i < 4; i++) begin
            int w;
            logic [15:0] d;
            w = (last_g == 0) ? 1 : 0;
            last_g = w;
            tick();
            check("tie_sel", vsel, 1);
            check("tie_addr", vaddr, addr[w]);
            check("tie_fp_addr", fvaddr, addr[0]);
            d = 16'($urandom);
            vack = 1'b1;
            vrd = d;
            tick();
            vack = 1'b0;
            exp_rd[w] = d;
            check("tie_ack", {ack1, ack0}, (w == 1) ? 2'b10 : 2'b01);
            check("tie_fp_ack", {fack1, fack0}, 2'b01);
            if (i == 3) begin
                sel = '0;
                act[0] = 1'b0;
                act[1] = 1'b0;
            end
            tick();
            check("tie_idle_acks", {ack1, ack0}, 0);
        end

        new_req(0, 1'b1, 4'hF, 24'h800010, 16'h0F0F);
        run_xact(2, 1'b0, 16'h1234);
        new_req(1, 1'b0, 4'h0, 24'h800000, 16'h0000);
        run_xact(0, 1'b0, 16'hABCD);

        // Reset while an access is in flight, then a fresh m1 request.
        new_req(1, 1'b1, 4'h5, 24'h123456, 16'h7777);
        tick();
        check("rst_busy_sel", vsel, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        last_g = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        new_req(1, 1'b0, 4'h3, 24'h0ABCDE, 16'h5A5A);
        #1;
        reset_n = 1'b1;
        run_xact(1, 1'b0, 16'h2468);

        for (int t = 0; t < 150; t++) begin
            if (!act[0] && !act[1]) begin
                repeat ($urandom_range(0, 2)) begin
                    vack = 1'($urandom_range(0, 1));
                    vrd = 16'($urandom);
                    tick();
                    vack = 1'b0;
                    check("gap_sel", vsel, 0);
                    check("gap_acks", {ack1, ack0}, 0);
                    check("gap_rd0", rd0, exp_rd[0]);
                    check("gap_rd1", rd1, exp_rd[1]);
                end
            end
            for (int n = 0; n < 2; n++)
                if (!act[n] && $urandom_range(0, 1) == 1) rand_req(n);
            if (!act[0] && !act[1]) rand_req(int'($urandom_range(0, 1)));
            run_xact(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 16'($urandom));
        end
        while (act[0] || act[1])
            run_xact(0, 1'b0, 16'($urandom));

`ifdef VRAM_ARBITER_STATS_EN
        st_clr = 1'b1;
        tick();
        st_clr = 1'b0;
        check("stat_clr0", st0, 0);
        check("stat_clr1", st1, 0);
        repeat (3) begin
            rand_req(0);
            run_xact(0, 1'b0, 16'($urandom));
        end
        check("stat_three", st0, 3);
        check("stat_other", st1, 0);
        force dut.u_stat0.r_count = 16'hFFFF;
        tick();
        release dut.u_stat0.r_count;
        rand_req(0);
        run_xact(0, 1'b0, 16'($urandom));
        check("stat_sat", st0, 16'hFFFF);
        st_clr = 1'b1;
        tick();
        st_clr = 1'b0;
        check("stat_clr_after", st0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
